// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   Pipeline register between the decode (D) and execute (E) stages of a
//   five-stage MIPS-style core. It also holds the E-stage operand
//   forwarding muxes, the ALU source-B mux and the destination-register mux.
//
//   Register update priority on each rising clk edge:
//     reset_n=0  >  flush_e=1  >  stall_e=1  >  normal capture
//
// Configuration:
//   FORWARDING_EN  When defined, the A and B operands come from the
//                  forwarding muxes. forward_*_e selects the source:
//                  00 = registered register-file read, 10 = aluout_m,
//                  01 = result_w, 11 = registered register-file read.
//                  When undefined, the operands are always the registered
//                  register-file reads. The forward selects, aluout_m and
//                  result_w are then ignored.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   stall_e, flush_e        hold E-stage contents / load a bubble
//   rd1_d, rd2_d, signimm_d D-stage operands and sign-extended immediate
//   rs_d, rt_d, rd_d        D-stage register indices
//   alucontrol_d            ALU function code (passed through unchanged)
//   alusrc_d .. valid_d     D-stage control bits
//   forward_a_e/b_e         forward selects from the hazard unit
//   aluout_m, result_w      forwarding sources from the M and W stages
//   src_a_e, src_b_e        ALU operands
//   alucontrol_e            registered ALU function
//   writedata_e             forwarded rt value for stores
//   rs_e, rt_e, writereg_e  hazard-unit indices and destination register
//   regwrite_e .. valid_e   registered control bits
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_e,
  input  logic               flush_e,
  input  logic [WIDTH-1:0]   rd1_d,
  input  logic [WIDTH-1:0]   rd2_d,
  input  logic [WIDTH-1:0]   signimm_d,
  input  logic [REGBITS-1:0] rs_d,
  input  logic [REGBITS-1:0] rt_d,
  input  logic [REGBITS-1:0] rd_d,
  input  logic [2:0]         alucontrol_d,
  input  logic               alusrc_d,
  input  logic               regdst_d,
  input  logic               regwrite_d,
  input  logic               memwrite_d,
  input  logic               memtoreg_d,
  input  logic               valid_d,
  input  logic [1:0]         forward_a_e,
  input  logic [1:0]         forward_b_e,
  input  logic [WIDTH-1:0]   aluout_m,
  input  logic [WIDTH-1:0]   result_w,
  output logic [WIDTH-1:0]   src_a_e,
  output logic [WIDTH-1:0]   src_b_e,
  output logic [2:0]         alucontrol_e,
  output logic [WIDTH-1:0]   writedata_e,
  output logic [REGBITS-1:0] rs_e,
  output logic [REGBITS-1:0] rt_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic               regwrite_e,
  output logic               memwrite_e,
  output logic               memtoreg_e,
  output logic               valid_e
);

  // Registered copies of the D-stage values that are not visible directly
  // as outputs. They feed the combinational E-stage muxes below.
  logic [WIDTH-1:0]   rd1_e;
  logic [WIDTH-1:0]   rd2_e;
  logic [WIDTH-1:0]   signimm_e;
  logic [REGBITS-1:0] rd_e;
  logic               alusrc_e;
  logic               regdst_e;

  // Forwarded operand values before the ALU source-B mux.
  logic [WIDTH-1:0]   fwd_a;
  logic [WIDTH-1:0]   fwd_b;

  // Pipeline register.
  // Reset and flush both load the all-zero bubble. Reset is tested first,
  // so it also overrides stall. A stall keeps the current contents, which
  // happens simply because there is no assignment on that path.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_e) begin
      rd1_e        <= '0;
      rd2_e        <= '0;
      signimm_e    <= '0;
      rs_e         <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
      alucontrol_e <= 3'd0;
      alusrc_e     <= 1'b0;
      regdst_e     <= 1'b0;
      regwrite_e   <= 1'b0;
      memwrite_e   <= 1'b0;
      memtoreg_e   <= 1'b0;
      valid_e      <= 1'b0;
    end else if (!stall_e) begin
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      signimm_e    <= signimm_d;
      rs_e         <= rs_d;
      rt_e         <= rt_d;
      rd_e         <= rd_d;
      alucontrol_e <= alucontrol_d;
      alusrc_e     <= alusrc_d;
      regdst_e     <= regdst_d;
      regwrite_e   <= regwrite_d;
      memwrite_e   <= memwrite_d;
      memtoreg_e   <= memtoreg_d;
      valid_e      <= valid_d;
    end
  end

`ifdef FORWARDING_EN
  // Operand A forwarding.
  // This path is purely combinational, so a newer value from the M or W
  // stage reaches the ALU in the same cycle the hazard unit selects it.
  // Select 11 is unused by the hazard unit and falls back to the
  // registered read.
  always_comb begin
    fwd_a = rd1_e;
    case (forward_a_e)
      2'b10:   fwd_a = aluout_m;
      2'b01:   fwd_a = result_w;
      default: fwd_a = rd1_e;
    endcase
  end

  // Operand B forwarding. It uses the same encoding as operand A.
  always_comb begin
    fwd_b = rd2_e;
    case (forward_b_e)
      2'b10:   fwd_b = aluout_m;
      2'b01:   fwd_b = result_w;
      default: fwd_b = rd2_e;
    endcase
  end
`else
  // Without forwarding, the operands are always the registered
  // register-file reads. The forwarding inputs are reduced into a
  // deliberately unused net so the ports remain in the interface.
  logic unused_fwd;

  always_comb begin
    fwd_a = rd1_e;
    fwd_b = rd2_e;
  end

  assign unused_fwd = ^{forward_a_e, forward_b_e, aluout_m, result_w};
`endif

  // E-stage output muxes.
  // Stores always take the forwarded rt value in writedata_e, even when the
  // ALU uses the immediate as operand B.
  always_comb begin
    src_a_e     = fwd_a;
    src_b_e     = alusrc_e ? signimm_e : fwd_b;
    writedata_e = fwd_b;
    writereg_e  = regdst_e ? rd_e : rt_e;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Purpose:
//   Scoreboard testbench for id_ex_stage.
//
//   The stimulus process drives one set of inputs per cycle. It advances a
//   behavioural model of the stage contents and pushes the predicted
//   outputs into a queue. A monitor process pops that queue on every
//   falling edge and compares the prediction with the DUT outputs.
//
//   Directed sequences come first: capture, forwarding, immediate and
//   destination, stall then flush, and reset during a stall. Randomized
//   cycles follow.
//
// Configuration:
//   FORWARDING_EN  The model follows the same macro as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int WIDTH   = 32;
  localparam int REGBITS = 5;

  // One D-stage instruction: everything the stage captures.
  typedef struct packed {
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
    logic [2:0]         alu;
    logic               alusrc;
    logic               regdst;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
    logic               valid;
  } dstage_t;

  // One set of predicted E-stage outputs.
  typedef struct packed {
    logic [WIDTH-1:0]   srca;
    logic [WIDTH-1:0]   srcb;
    logic [WIDTH-1:0]   wdata;
    logic [2:0]         alu;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] wreg;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
    logic               valid;
  } expect_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stall_e = 1'b0;
  logic flush_e = 1'b0;
  logic [1:0] forward_a_e = 2'b00;
  logic [1:0] forward_b_e = 2'b00;
  logic [WIDTH-1:0] aluout_m = '0;
  logic [WIDTH-1:0] result_w = '0;
  dstage_t dIn = '0;

  logic [WIDTH-1:0]   src_a_e;
  logic [WIDTH-1:0]   src_b_e;
  logic [2:0]         alucontrol_e;
  logic [WIDTH-1:0]   writedata_e;
  logic [REGBITS-1:0] rs_e;
  logic [REGBITS-1:0] rt_e;
  logic [REGBITS-1:0] writereg_e;
  logic               regwrite_e;
  logic               memwrite_e;
  logic               memtoreg_e;
  logic               valid_e;

  expect_t expQ[$];
  dstage_t modelState = '0;
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_e      (stall_e),
    .flush_e      (flush_e),
    .rd1_d        (dIn.rd1),
    .rd2_d        (dIn.rd2),
    .signimm_d    (dIn.imm),
    .rs_d         (dIn.rs),
    .rt_d         (dIn.rt),
    .rd_d         (dIn.rd),
    .alucontrol_d (dIn.alu),
    .alusrc_d     (dIn.alusrc),
    .regdst_d     (dIn.regdst),
    .regwrite_d   (dIn.regwrite),
    .memwrite_d   (dIn.memwrite),
    .memtoreg_d   (dIn.memtoreg),
    .valid_d      (dIn.valid),
    .forward_a_e  (forward_a_e),
    .forward_b_e  (forward_b_e),
    .aluout_m     (aluout_m),
    .result_w     (result_w),
    .src_a_e      (src_a_e),
    .src_b_e      (src_b_e),
    .alucontrol_e (alucontrol_e),
    .writedata_e  (writedata_e),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .writereg_e   (writereg_e),
    .regwrite_e   (regwrite_e),
    .memwrite_e   (memwrite_e),
    .memtoreg_e   (memtoreg_e),
    .valid_e      (valid_e)
  );

  // Stage contents after one clock edge.
  // Reset or flush yields an empty instruction. A stall keeps the old one.
  // Otherwise the stage takes the new instruction.
  function automatic dstage_t nextState(dstage_t cur, dstage_t din,
                                        logic rstN, logic stall, logic flush);
    if (!rstN || flush) return '0;
    if (stall) return cur;
    return din;
  endfunction

  // Predicted outputs for the given stage contents and this cycle's
  // forwarding inputs. Each select value indexes a table of sources.
  function automatic expect_t predict(dstage_t s, logic [1:0] fa, logic [1:0] fb,
                                      logic [WIDTH-1:0] am, logic [WIDTH-1:0] rw);
    logic [WIDTH-1:0] srcA [4];
    logic [WIDTH-1:0] srcB [4];
    expect_t e;
`ifdef FORWARDING_EN
    srcA = '{s.rd1, rw, am, s.rd1};
    srcB = '{s.rd2, rw, am, s.rd2};
`else
    srcA = '{s.rd1, s.rd1, s.rd1, s.rd1};
    srcB = '{s.rd2, s.rd2, s.rd2, s.rd2};
`endif
    e.srca     = srcA[fa];
    e.wdata    = srcB[fb];
    e.srcb     = s.alusrc ? s.imm : srcB[fb];
    e.alu      = s.alu;
    e.rs       = s.rs;
    e.rt       = s.rt;
    e.wreg     = s.regdst ? s.rd : s.rt;
    e.regwrite = s.regwrite;
    e.memwrite = s.memwrite;
    e.memtoreg = s.memtoreg;
    e.valid    = s.valid;
    return e;
  endfunction

  // Random instruction. All eight ALU codes are possible, so the
  // unused codes 3-5 also pass through.
  function automatic dstage_t randD();
    dstage_t d;
    d.rd1      = $urandom;
    d.rd2      = $urandom;
    d.imm      = $urandom;
    d.rs       = REGBITS'($urandom_range(31, 0));
    d.rt       = REGBITS'($urandom_range(31, 0));
    d.rd       = REGBITS'($urandom_range(31, 0));
    d.alu      = 3'($urandom_range(7, 0));
    d.alusrc   = 1'($urandom_range(1, 0));
    d.regdst   = 1'($urandom_range(1, 0));
    d.regwrite = 1'($urandom_range(1, 0));
    d.memwrite = 1'($urandom_range(1, 0));
    d.memtoreg = 1'($urandom_range(1, 0));
    d.valid    = 1'($urandom_range(1, 0));
    return d;
  endfunction

  // Runs one cycle. After the rising edge, the model applies the inputs
  // that were present at that edge. The task then drives the new inputs
  // and queues the outputs expected for the rest of the cycle.
  task automatic applyStimulus(input dstage_t d, input logic rstN, input logic stall,
                               input logic flush, input logic [1:0] fa, input logic [1:0] fb,
                               input logic [WIDTH-1:0] am, input logic [WIDTH-1:0] rw);
    @(posedge clk);
    #1;
    modelState = nextState(modelState, dIn, reset_n, stall_e, flush_e);
    dIn = d;
    reset_n = rstN;
    stall_e = stall;
    flush_e = flush;
    forward_a_e = fa;
    forward_b_e = fb;
    aluout_m = am;
    result_w = rw;
    expQ.push_back(predict(modelState, fa, fb, am, rw));
  endtask

  // Compares one DUT output with its prediction and counts the result.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] got,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, got, exp);
    end
  endtask

  // Monitor: on each falling edge, pops the oldest prediction and
  // compares every output with it.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("src_a_e",      src_a_e,      e.srca);
        checkOutput("src_b_e",      src_b_e,      e.srcb);
        checkOutput("writedata_e",  writedata_e,  e.wdata);
        checkOutput("alucontrol_e", WIDTH'(alucontrol_e), WIDTH'(e.alu));
        checkOutput("rs_e",         WIDTH'(rs_e),         WIDTH'(e.rs));
        checkOutput("rt_e",         WIDTH'(rt_e),         WIDTH'(e.rt));
        checkOutput("writereg_e",   WIDTH'(writereg_e),   WIDTH'(e.wreg));
        checkOutput("regwrite_e",   WIDTH'(regwrite_e),   WIDTH'(e.regwrite));
        checkOutput("memwrite_e",   WIDTH'(memwrite_e),   WIDTH'(e.memwrite));
        checkOutput("memtoreg_e",   WIDTH'(memtoreg_e),   WIDTH'(e.memtoreg));
        checkOutput("valid_e",      WIDTH'(valid_e),      WIDTH'(e.valid));
      end
    end
  end

  // Watchdog: stops the run if the stimulus never completes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed sequences first, then random cycles.
  initial begin
    dstage_t d;
    logic rstN;
    logic stall;
    logic flush;

    $display("[TB] start");

    // Reset for two edges, then an idle cycle.
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus('0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

    // Capture: a SUB with registered operands 5 and 3.
    d = '0;
    d.rd1 = 32'd5;
    d.rd2 = 32'd3;
    d.alu = 3'd6;
    d.valid = 1'b1;
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

    // Forwarding: registered rd1 is 1. Operand A comes first from
    // aluout_m, then from result_w, in the same cycle as each change.
    d = '0;
    d.rd1 = 32'd1;
    d.valid = 1'b1;
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 32'hAA, '0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 32'hAA, 32'hBB);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01, 32'hAA, 32'hBB);

    // Immediate and destination: the immediate drives operand B, rt data
    // drives writedata, and rd is the destination register.
    d = '0;
    d.alusrc = 1'b1;
    d.imm = 32'hFFFF_FFFC;
    d.regdst = 1'b1;
    d.rd = 5'd7;
    d.rt = 5'd4;
    d.rd2 = 32'd9;
    d.regwrite = 1'b1;
    d.valid = 1'b1;
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

    // Stall for three edges while the D inputs change, then assert flush
    // and stall together. Flush wins.
    d = randD();
    d.regwrite = 1'b1;
    d.memwrite = 1'b1;
    d.valid = 1'b1;
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    for (int i = 0; i < 3; i++)
      applyStimulus(randD(), 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

    // Reset during a stall that holds a regwrite instruction. The first
    // edge after release captures the current D inputs.
    d = randD();
    d.regwrite = 1'b1;
    d.valid = 1'b1;
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
    applyStimulus(randD(), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);

    // Random traffic: stalls, flushes, occasional resets and all
    // forward selects.
    for (int i = 0; i < 400; i++) begin
      rstN  = ($urandom_range(99, 0) >= 4);
      stall = ($urandom_range(99, 0) < 25);
      flush = ($urandom_range(99, 0) < 12);
      applyStimulus(randD(), rstN, stall, flush,
                    2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                    $urandom, $urandom);
    end

    // Wait for the monitor to compare the last queued prediction, then
    // confirm nothing is left in the queue.
    @(negedge clk);
    #1;
    checkOutput("queue_drained", WIDTH'(expQ.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
